// File: rtl/branch_predict_unit_pkg.sv
// Shared pipeline definitions: branch op codes, redirect select codes and
// 2-bit predictor counter states used by the branch predict unit.
package pipeline_defs;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    localparam logic [1:0] SEL_SEQ      = 2'd0;
    localparam logic [1:0] SEL_TARGET   = 2'd1;
    localparam logic [1:0] SEL_FALLTHRU = 2'd2;
    localparam logic [1:0] SEL_JUMP     = 2'd3;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF/ID-side signal bundle of the branch predict unit; master drives the
// pipeline inputs, slave is the predictor itself.
interface branch_predict_unit_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic              if_pred_taken;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [2:0]        id_branch_op;
    logic              id_jump;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic              id_taken;
    logic              id_mispredict;
    logic [1:0]        redirect_sel;
    logic              flush;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    modport master (
        output stall, if_valid, if_pc, id_valid, id_pc, id_branch_op, id_jump,
               id_rs_data, id_rt_data,
        input  if_pred_taken, id_taken, id_mispredict, redirect_sel, flush,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  stall, if_valid, if_pc, id_valid, id_pc, id_branch_op, id_jump,
               id_rs_data, id_rt_data,
        output if_pred_taken, id_taken, id_mispredict, redirect_sel, flush,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// 2-bit saturating up/down counter; one instance per BHT entry.
module sat_counter2
    import pipeline_defs::*;
#(
    parameter logic [1:0] INIT = CTR_WNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output logic [1:0] q
);
    logic [1:0] ctr_r;
    logic [1:0] ctr_nxt_s;

    // Step toward the requested end, clamping at strongly taken / not-taken.
    always_comb begin
        ctr_nxt_s = ctr_r;
        if (!en) begin
            ctr_nxt_s = ctr_r;
        end else if (up) begin
            ctr_nxt_s = (ctr_r == CTR_ST) ? ctr_r : ctr_r + 2'd1;
        end else begin
            ctr_nxt_s = (ctr_r == CTR_SNT) ? ctr_r : ctr_r - 2'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_r <= INIT;
        end else begin
            ctr_r <= ctr_nxt_s;
        end
    end

    assign q = ctr_r;
endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage branch resolution and redirect select with an IF-stage bimodal
// predictor (BHT of 2-bit counters) plus branch/mispredict statistics.
module branch_predict_unit
    import pipeline_defs::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         PC_W        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         IDX_W       = 6,
    parameter logic [1:0] INIT_CTR    = 2'b01,
    parameter int         CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    logic [1:0]       bht_s [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] id_idx_s;
    logic             pred_s;
    logic             id_pred_r;
    logic             active_s;
    logic             is_op_s;
    logic             br_s;
    logic             cond_s;
    logic             taken_s;
    logic             mispred_s;
    logic [1:0]       sel_s;
    logic             flush_s;
    logic             rs_neg_s;
    logic             rs_zero_s;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;
    logic             unused_s;

    assign if_idx_s = bus.if_pc[IDX_W+1:2];
    assign id_idx_s = bus.id_pc[IDX_W+1:2];
    // Lookup reads the flops directly, so a same-cycle update is not bypassed.
    assign pred_s   = bus.if_valid & bht_s[if_idx_s][1];

    genvar g;
    generate
        for (g = 0; g < BHT_ENTRIES; g++) begin : g_bht
            sat_counter2 #(.INIT(INIT_CTR)) u_ctr (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (br_s && (id_idx_s == IDX_W'(g))),
                .up    (cond_s),
                .q     (bht_s[g])
            );
        end
    endgenerate

    assign rs_neg_s  = bus.id_rs_data[DATA_W-1];
    assign rs_zero_s = (bus.id_rs_data == {DATA_W{1'b0}});

    // Branch condition for the op in ID, zero tests are two's-complement signed.
    always_comb begin
        cond_s = 1'b0;
        case (bus.id_branch_op)
            BR_BEQ:  cond_s = (bus.id_rs_data == bus.id_rt_data);
            BR_BNE:  cond_s = (bus.id_rs_data != bus.id_rt_data);
            BR_BLEZ: cond_s = rs_neg_s | rs_zero_s;
            BR_BGTZ: cond_s = ~rs_neg_s & ~rs_zero_s;
            BR_BLTZ: cond_s = rs_neg_s;
            BR_BGEZ: cond_s = ~rs_neg_s;
            default: cond_s = 1'b0;
        endcase
    end

    assign active_s  = bus.id_valid & ~bus.stall;
    assign is_op_s   = (bus.id_branch_op >= BR_BEQ) && (bus.id_branch_op <= BR_BGEZ);
    assign br_s      = active_s & ~bus.id_jump & is_op_s;
    assign taken_s   = br_s & cond_s;
    assign mispred_s = br_s & (cond_s ^ id_pred_r);

    // Redirect select: jumps win over any branch op encoded alongside them.
    always_comb begin
        sel_s = SEL_SEQ;
        if (active_s && bus.id_jump) begin
            sel_s = SEL_JUMP;
        end else if (mispred_s && cond_s) begin
            sel_s = SEL_TARGET;
        end else if (mispred_s) begin
            sel_s = SEL_FALLTHRU;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    assign flush_s = (sel_s != SEL_SEQ);

    // Prediction travelling with the instruction from IF into ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pred_r <= 1'b0;
        end else if (flush_s) begin
            id_pred_r <= 1'b0;
        end else if (!bus.stall) begin
            id_pred_r <= pred_s;
        end
    end

    // Saturating statistics counters, stepped with the BHT update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (br_s && (branch_cnt_r != {CNT_W{1'b1}})) begin
                branch_cnt_r <= branch_cnt_r + CNT_W'(1);
            end
            if (mispred_s && (mispred_cnt_r != {CNT_W{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.if_pred_taken = pred_s;
    assign bus.id_taken      = taken_s;
    assign bus.id_mispredict = mispred_s;
    assign bus.redirect_sel  = sel_s;
    assign bus.flush         = flush_s;
    assign bus.branch_cnt    = branch_cnt_r;
    assign bus.mispred_cnt   = mispred_cnt_r;

    // Target arithmetic lives outside this block; only index bits are consumed.
    assign unused_s = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                        bus.id_pc[PC_W-1:IDX_W+2], bus.id_pc[1:0]};
endmodule
